// File: rtl/game_pkg.sv
// Shared playfield geometry and ship state encoding for the ship hit manager
// and its per-bullet hitbox comparator.
`timescale 1ns/1ps
package game_pkg;

    localparam int COORD_W         = 11;
    localparam int SHIP_Y_TOP      = 680;
    localparam int SHIP_HEIGHT     = 32;
    localparam int HALF_SHIP_WIDTH = 24;

    localparam logic [1:0] ST_ALIVE  = 2'd0;
    localparam logic [1:0] ST_INVULN = 2'd1;
    localparam logic [1:0] ST_DEAD   = 2'd2;

endpackage

// File: rtl/hitbox_cmp.sv
// One enemy bullet against the ship hitbox; purely combinational, bounds are
// computed one bit wider than the coordinates so they can clamp and saturate.
`timescale 1ns/1ps
module hitbox_cmp
    import game_pkg::*;
#(
    parameter int CMP_W     = game_pkg::COORD_W,
    parameter int Y_TOP     = game_pkg::SHIP_Y_TOP,
    parameter int HEIGHT    = game_pkg::SHIP_HEIGHT,
    parameter int HALF_W    = game_pkg::HALF_SHIP_WIDTH
) (
    input  logic [CMP_W-1:0] ship_x,
    input  logic [CMP_W-1:0] bullet_x,
    input  logic [CMP_W-1:0] bullet_y,
    output logic             hit
);

    localparam int EW = CMP_W + 1;
    localparam logic [EW-1:0] HALF_E = EW'(HALF_W);
    localparam logic [EW-1:0] MAX_X  = EW'((1 << CMP_W) - 1);
    localparam logic [EW-1:0] Y_LO   = EW'(Y_TOP);
    localparam logic [EW-1:0] Y_HI   = EW'(Y_TOP + HEIGHT - 1);

    logic [EW-1:0] ship_e_s;
    logic [EW-1:0] sum_e_s;
    logic [EW-1:0] x_lo_s;
    logic [EW-1:0] x_hi_s;
    logic [EW-1:0] bx_e_s;
    logic [EW-1:0] by_e_s;

    // Horizontal window clamps at 0 on the left and saturates on the right edge.
    always_comb begin
        ship_e_s = {1'b0, ship_x};
        bx_e_s   = {1'b0, bullet_x};
        by_e_s   = {1'b0, bullet_y};
        sum_e_s  = ship_e_s + HALF_E;
        if (ship_e_s < HALF_E) begin
            x_lo_s = '0;
        end else begin
            x_lo_s = ship_e_s - HALF_E;
        end
        if (sum_e_s > MAX_X) begin
            x_hi_s = MAX_X;
        end else begin
            x_hi_s = sum_e_s;
        end
        hit = (bx_e_s >= x_lo_s) && (bx_e_s <= x_hi_s) &&
              (by_e_s >= Y_LO)   && (by_e_s <= Y_HI);
    end

endmodule

// File: rtl/ship_hit_manager.sv
// Bullet/ship collision, lives and invulnerability manager.
// Optional macro SHIP_HIT_SHIELD_EN adds a shield_on input that absorbs hits.
`timescale 1ns/1ps
module ship_hit_manager
    import game_pkg::*;
#(
    parameter int N_BULLETS       = 5,
    parameter int COORD_W         = game_pkg::COORD_W,
    parameter int SHIP_Y_TOP      = game_pkg::SHIP_Y_TOP,
    parameter int SHIP_HEIGHT     = game_pkg::SHIP_HEIGHT,
    parameter int HALF_SHIP_WIDTH = game_pkg::HALF_SHIP_WIDTH,
    parameter int LIVES           = 3,
    parameter int INVULN_FRAMES   = 120
) (
    input  logic                           pclk,
    input  logic                           rst,
    input  logic                           frame_tick,
    input  logic                           restart,
`ifdef SHIP_HIT_SHIELD_EN
    input  logic                           shield_on,
`endif
    input  logic [COORD_W-1:0]             ship_x,
    input  logic [N_BULLETS*COORD_W-1:0]   en_bullet_x,
    input  logic [N_BULLETS*COORD_W-1:0]   en_bullet_y,
    output logic [N_BULLETS-1:0]           bullet_hit,
    output logic                           ship_hit,
    output logic [2:0]                     lives_left,
    output logic                           invulnerable,
    output logic                           is_ship_dead
);

    localparam int                CNT_W    = $clog2(INVULN_FRAMES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(INVULN_FRAMES - 1);
    localparam logic [2:0]        LIVES_V  = 3'(LIVES);

    logic [N_BULLETS-1:0] hit_raw_s;
    logic                 shield_s;

    logic [N_BULLETS-1:0] hit_vec_q,    hit_vec_d;
    logic [N_BULLETS-1:0] bullet_hit_q, bullet_hit_d;
    logic                 ship_hit_q,   ship_hit_d;
    logic [1:0]           state_q,      state_d;
    logic [2:0]           lives_q,      lives_d;
    logic [CNT_W-1:0]     cnt_q,        cnt_d;

    genvar k;
    generate
        for (k = 0; k < N_BULLETS; k++) begin : g_cmp
            hitbox_cmp #(
                .CMP_W  (COORD_W),
                .Y_TOP  (SHIP_Y_TOP),
                .HEIGHT (SHIP_HEIGHT),
                .HALF_W (HALF_SHIP_WIDTH)
            ) u_cmp (
                .ship_x   (ship_x),
                .bullet_x (en_bullet_x[k*COORD_W +: COORD_W]),
                .bullet_y (en_bullet_y[k*COORD_W +: COORD_W]),
                .hit      (hit_raw_s[k])
            );
        end
    endgenerate

`ifdef SHIP_HIT_SHIELD_EN
    assign shield_s = shield_on;
`else
    assign shield_s = 1'b0;
`endif

    // Stage-2 FSM: acts on the registered hit vector, one life per ALIVE exit.
    always_comb begin
        hit_vec_d    = hit_raw_s;
        state_d      = state_q;
        lives_d      = lives_q;
        cnt_d        = cnt_q;
        bullet_hit_d = '0;
        ship_hit_d   = 1'b0;
        case (state_q)
            ST_ALIVE: begin
                if (hit_vec_q != '0) begin
                    bullet_hit_d = hit_vec_q;
                    if (!shield_s) begin
                        ship_hit_d = 1'b1;
                        lives_d    = lives_q - 3'd1;
                        cnt_d      = '0;
                        state_d    = (lives_q == 3'd1) ? ST_DEAD : ST_INVULN;
                    end else begin
                        state_d = ST_ALIVE;
                    end
                end else begin
                    state_d = ST_ALIVE;
                end
            end
            ST_INVULN: begin
                if (frame_tick) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_ALIVE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_DEAD: begin
                if (restart) begin
                    state_d = ST_ALIVE;
                    lives_d = LIVES_V;
                end else begin
                    state_d = ST_DEAD;
                end
            end
            default: begin
                state_d = ST_ALIVE;
                cnt_d   = '0;
            end
        endcase
    end

    // Pipeline, FSM and output registers; reset drops any pending pulse.
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            hit_vec_q    <= '0;
            bullet_hit_q <= '0;
            ship_hit_q   <= 1'b0;
            state_q      <= ST_ALIVE;
            lives_q      <= LIVES_V;
            cnt_q        <= '0;
        end else begin
            hit_vec_q    <= hit_vec_d;
            bullet_hit_q <= bullet_hit_d;
            ship_hit_q   <= ship_hit_d;
            state_q      <= state_d;
            lives_q      <= lives_d;
            cnt_q        <= cnt_d;
        end
    end

    assign bullet_hit   = bullet_hit_q;
    assign ship_hit     = ship_hit_q;
    assign lives_left   = lives_q;
    assign invulnerable = (state_q == ST_INVULN);
    assign is_ship_dead = (state_q == ST_DEAD);

endmodule
